fp16_dot_seq: RTL and testbench

//  Sequencer for one mac_fp16 instance: accepts a dot-product command of length N,

---
 rtl/fp16_dot_seq_if.sv | 30 +++
 rtl/fp16_dot_seq.sv | 89 ++++++++
 tb/tb_fp16_dot_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_dot_seq_if.sv
// Command / operand / result handshake bundle between the GEMM feeder and the
// FP16 dot-product sequencer.
interface fp16_dot_seq_if #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_nan;
  logic              res_inf;

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_nan, res_inf
  );

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_nan, res_inf
  );
endinterface

// File: rtl/fp16_dot_seq.sv
// Sequencer for one FP16 MAC lane: clears the accumulator, streams N operand
// pairs, drains the 2-stage MAC pipeline and returns the FP32 result.
module fp16_dot_seq #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  fp16_dot_seq_if.slave     bus,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, count;
  logic             drain_2nd;
  logic [ACC_W-1:0] res_data;
  logic             cmd_hs, op_hs, last_beat;

  always_comb begin
    cmd_hs    = (state == S_IDLE) && bus.cmd_valid && !abort;
    op_hs     = (state == S_STREAM) && bus.op_valid;
    last_beat = op_hs && (count == len - LEN_W'(1));
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_hs) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = (len == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_2nd) state_nxt = S_RESULT;
      S_RESULT: if (bus.res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      count     <= '0;
      drain_2nd <= 1'b0;
      res_data  <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        count     <= '0;
        drain_2nd <= 1'b0;
      end else begin
        if (cmd_hs) begin
          len   <= bus.cmd_len;
          count <= '0;
        end
        if (op_hs) count <= count + LEN_W'(1);
        // Second drain cycle: the last product is visible on mac_acc now.
        if (state == S_DRAIN) begin
          drain_2nd <= ~drain_2nd;
          if (drain_2nd) res_data <= mac_acc;
        end
      end
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.op_ready  = (state == S_STREAM);
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = res_data;
  assign bus.res_nan   = (res_data[30:23] == 8'hFF) && (res_data[22:0] != '0);
  assign bus.res_inf   = (res_data[30:23] == 8'hFF) && (res_data[22:0] == '0);
  assign busy          = (state != S_IDLE);
  assign mac_clear     = (state == S_CLEAR);
  assign mac_en        = op_hs;
  assign mac_a         = bus.op_a;
  assign mac_b         = bus.op_b;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Bench for fp16_dot_seq: behavioural FP16 MAC lane plus a dot-product
// reference computed from the operand lists.
module tb_fp16_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        mac_clear, mac_en, busy;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_acc = '0;

  fp16_dot_seq_if #(.LEN_W(16), .DATA_W(16), .ACC_W(32)) bus ();

  fp16_dot_seq #(.LEN_W(16), .DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus.slave),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int en_cnt  = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_en) en_cnt <= en_cnt + 1;
  end

  // Number kinds: 0 finite, 1 +inf, 2 -inf, 3 NaN
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic void f16_dec(input logic [15:0] h, output int k, output real v);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    v = 0.0;
    if (e == 31) k = (m != 0) ? 3 : (h[15] ? 2 : 1);
    else begin
      k = 0;
      v = (e == 0) ? real'(m) * pow2(-24) : real'(1024 + m) * pow2(e - 25);
      if (h[15]) v = -v;
    end
  endfunction

  function automatic void n_mul(input int ka, input real va, input int kb, input real vb,
                                output int k, output real v);
    bit na, nb;
    v = 0.0;
    if (ka == 3 || kb == 3) k = 3;
    else if (ka != 0 || kb != 0) begin
      if ((ka == 0 && va == 0.0) || (kb == 0 && vb == 0.0)) k = 3;
      else begin
        na = (ka == 2) || (ka == 0 && va < 0.0);
        nb = (kb == 2) || (kb == 0 && vb < 0.0);
        k  = (na ^ nb) ? 2 : 1;
      end
    end else begin
      k = 0;
      v = va * vb;
    end
  endfunction

  function automatic void n_add(input int ka, input real va, input int kb, input real vb,
                                output int k, output real v);
    v = 0.0;
    if (ka == 3 || kb == 3)      k = 3;
    else if (ka != 0 && kb != 0) k = (ka == kb) ? ka : 3;
    else if (ka != 0)            k = ka;
    else if (kb != 0)            k = kb;
    else begin
      k = 0;
      v = va + vb;
    end
  endfunction

  function automatic logic [31:0] n_enc(input int k, input real v);
    real         x;
    int          e = 0;
    logic [7:0]  eb;
    logic [22:0] mb;
    if (k == 3) return 32'h7FC0_0000;
    if (k == 1) return 32'h7F80_0000;
    if (k == 2) return 32'hFF80_0000;
    if (v == 0.0) return 32'h0000_0000;
    x = (v < 0.0) ? -v : v;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    if (e + 127 >= 255) return {(v < 0.0), 31'h7F80_0000};
    eb = 8'(e + 127);
    mb = 23'($rtoi((x - 1.0) * 8388608.0));
    return {(v < 0.0), eb, mb};
  endfunction

  function automatic logic [15:0] int_to_f16(input int x);
    int a = (x < 0) ? -x : x;
    int p = 0;
    logic [4:0] eb;
    logic [9:0] mb;
    if (x == 0) return 16'h0000;
    while ((a >> (p + 1)) != 0) p++;
    eb = 5'(15 + p);
    mb = 10'((a << (10 - p)) & 'h3FF);
    return {(x < 0), eb, mb};
  endfunction

  // MAC lane: en/clear at t are staged, take effect at the edge ending t+1
  int  acc_k = 0;
  real acc_v = 0.0;
  bit  p_en  = 1'b0;
  bit  p_clr = 1'b0;
  int  p_k   = 0;
  real p_v   = 0.0;

  always @(posedge clk) begin
    int  ka, kb, tk;
    real va, vb, tv;
    if (p_clr) begin
      acc_k = 0;
      acc_v = 0.0;
    end else if (p_en) begin
      n_add(acc_k, acc_v, p_k, p_v, tk, tv);
      acc_k = tk;
      acc_v = tv;
    end
    p_clr = mac_clear;
    p_en  = mac_en;
    f16_dec(mac_a, ka, va);
    f16_dec(mac_b, kb, vb);
    n_mul(ka, va, kb, vb, p_k, p_v);
    mac_acc <= n_enc(acc_k, acc_v);
  end

  logic [15:0] sa [64];
  logic [15:0] sb [64];
  int          sg [64];
  logic [31:0] r_data;
  logic        r_nan, r_inf;
  int          r_lat, r_lat0, r_en, r_bad;
  bit          r_to;

  task automatic run_dot(input int n, input int hold, input bit take);
    int en0, last, acc_c, t;
    r_to  = 1'b0;
    r_bad = 0;
    en0   = en_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 16'(n);
    t = 0;
    while (!bus.cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) r_to = 1'b1;
    acc_c = cyc;
    last  = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b0;
      repeat (sg[i]) begin @(posedge clk); #1; end
      bus.op_valid = 1'b1;
      bus.op_a     = sa[i];
      bus.op_b     = sb[i];
      t = 0;
      while (!bus.op_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (t >= 20) r_to = 1'b1;
      last = cyc;
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    bus.op_a     = 16'($urandom);
    bus.op_b     = 16'($urandom);
    t = 0;
    while (!bus.res_valid && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) r_to = 1'b1;
    r_lat  = cyc - last;
    r_lat0 = cyc - acc_c;
    r_data = bus.res_data;
    r_nan  = bus.res_nan;
    r_inf  = bus.res_inf;
    bus.op_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.res_data !== r_data || bus.res_valid !== 1'b1 ||
          bus.cmd_ready !== 1'b0 || bus.op_ready !== 1'b0) r_bad++;
    end
    bus.op_valid = 1'b0;
    if (take) begin
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end
    r_en = en_cnt - en0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.cmd_ready, bus.op_ready, bus.res_valid, busy, mac_en, mac_clear} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 100000",
               {bus.cmd_ready, bus.op_ready, bus.res_valid, busy, mac_en, mac_clear});
    end
    n_tests++;
    if (bus.res_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got %h exp 00000000", bus.res_data);
    end
  endtask

  task automatic test_basic(input int gap_mode, input int hold);
    sa[0] = 16'h3C00; sa[1] = 16'h4000; sa[2] = 16'h4200;
    sb[0] = 16'h4000; sb[1] = 16'h3800; sb[2] = 16'h3C00;
    sg[0] = (gap_mode != 0) ? 1 : 0;
    sg[1] = (gap_mode != 0) ? 3 : 0;
    sg[2] = 0;
    run_dot(3, hold, 1'b1);
    n_tests++;
    if (r_data !== 32'h40C0_0000 || r_to) begin
      n_fail++; $display("FAIL basic%0d_data got %h exp 40c00000 timeout=%0d", gap_mode, r_data, r_to);
    end
    n_tests++;
    if (r_lat !== 3) begin
      n_fail++; $display("FAIL basic%0d_latency got %0d exp 3", gap_mode, r_lat);
    end
    n_tests++;
    if (r_en !== 3 || r_bad !== 0) begin
      n_fail++; $display("FAIL basic%0d_en_hold got en=%0d bad=%0d exp en=3 bad=0", gap_mode, r_en, r_bad);
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic%0d_idle got cmd_ready=%b busy=%b exp 1 0", gap_mode, bus.cmd_ready, busy);
    end
  endtask

  task automatic test_len0();
    run_dot(0, 0, 1'b1);
    n_tests++;
    if (r_data !== 32'h0 || r_to) begin
      n_fail++; $display("FAIL len0_data got %h exp 00000000 timeout=%0d", r_data, r_to);
    end
    n_tests++;
    if (r_lat0 !== 4 || r_en !== 0) begin
      n_fail++; $display("FAIL len0_timing got lat=%0d en=%0d exp lat=4 en=0", r_lat0, r_en);
    end
  endtask

  task automatic test_nan();
    sa[0] = 16'h7C00; sb[0] = 16'h0000; sg[0] = 0;
    sa[1] = 16'h3C00; sb[1] = 16'h3C00; sg[1] = 0;
    run_dot(2, 0, 1'b1);
    n_tests++;
    if (r_data !== 32'h7FC0_0000 || r_nan !== 1'b1 || r_inf !== 1'b0 || r_to) begin
      n_fail++; $display("FAIL nan got data=%h nan=%b inf=%b exp 7fc00000 1 0", r_data, r_nan, r_inf);
    end
    sa[0] = 16'h7C00; sb[0] = 16'h3C00; sg[0] = 0;
    run_dot(1, 0, 1'b1);
    n_tests++;
    if (r_data !== 32'h7F80_0000 || r_nan !== 1'b0 || r_inf !== 1'b1 || r_to) begin
      n_fail++; $display("FAIL inf got data=%h nan=%b inf=%b exp 7f800000 0 1", r_data, r_nan, r_inf);
    end
  endtask

  task automatic test_abort();
    logic [31:0] held;
    bus.cmd_valid = 1'b1; bus.cmd_len = 16'd4;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_a = 16'h4400; bus.op_b = 16'h4400;
    repeat (2) begin @(posedge clk); #1; end
    bus.op_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_stream got cmd_ready=%b busy=%b op_ready=%b exp 1 0 0",
                         bus.cmd_ready, busy, bus.op_ready);
    end
    sa[0] = 16'h3C00; sb[0] = 16'h3C00; sg[0] = 0;
    run_dot(1, 0, 1'b1);
    n_tests++;
    if (r_data !== 32'h3F80_0000 || r_en !== 1 || r_to) begin
      n_fail++; $display("FAIL abort_next got data=%h en=%0d timeout=%0d exp 3f800000 1 0", r_data, r_en, r_to);
    end
    abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_len = 16'd1;
    @(posedge clk); #1;
    abort = 1'b0; bus.cmd_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || mac_clear !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_cmd got busy=%b clear=%b exp 0 0", busy, mac_clear);
    end
    sa[0] = 16'h4000; sb[0] = 16'h4200; sg[0] = 0;
    run_dot(1, 0, 1'b0);
    held = r_data;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 32'h40C0_0000 || held !== 32'h40C0_0000) begin
      n_fail++; $display("FAIL abort_result got valid=%b data=%h first=%h exp 0 40c00000 40c00000",
                         bus.res_valid, bus.res_data, held);
    end
  endtask

  task automatic test_random();
    int n, hold, sum, x, y;
    logic [31:0] exp_d;
    for (int it = 0; it < 20; it++) begin
      n    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      hold = int'($urandom_range(0, 2));
      sum  = 0;
      for (int i = 0; i < n; i++) begin
        x = int'($urandom_range(0, 12)) - 6;
        y = int'($urandom_range(0, 12)) - 6;
        sum += x * y;
        sa[i] = int_to_f16(x);
        sb[i] = int_to_f16(y);
        sg[i] = int'($urandom_range(0, 2));
      end
      run_dot(n, hold, 1'b1);
      exp_d = n_enc(0, real'(sum));
      n_tests++;
      if (r_data !== exp_d || r_to) begin
        n_fail++; $display("FAIL rand%0d_data n=%0d got %h exp %h timeout=%0d", it, n, r_data, exp_d, r_to);
      end
      n_tests++;
      if ((n > 0 && r_lat !== 3) || (n == 0 && r_lat0 !== 4)) begin
        n_fail++; $display("FAIL rand%0d_latency n=%0d got %0d/%0d exp 3/4", it, n, r_lat, r_lat0);
      end
      n_tests++;
      if (r_en !== n || r_bad !== 0) begin
        n_fail++; $display("FAIL rand%0d_en_hold got en=%0d bad=%0d exp en=%0d bad=0", it, r_en, r_bad, n);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.op_valid = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic(0, 0);
    test_basic(1, 0);
    test_len0();
    test_nan();
    test_basic(0, 5);
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
